// File: rtl/sq_multi_gen.sv
// Multi-channel square-wave generator. Each channel divides clk by a
// programmable half-period H (period 2*(H+1)); the channels are combined
// into one registered OR/XOR mix output.

// One square-wave channel: half-period register, counter and output flop.
module sq_multi_gen_ch #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_data,
  output logic             o_sq,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_h;
  logic [DIV_W-1:0] r_cnt;
  logic             r_sq;
  logic             r_tick;

  // A write beats both the enable and a terminal count: it reloads H,
  // restarts the count and holds the output without a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h    <= '0;
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_wr) begin
      r_h    <= i_wr_data;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_tick <= 1'b0;
    end else if (r_cnt == r_h) begin
      r_cnt  <= '0;
      r_sq   <= ~r_sq;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_sq   = r_sq;
  assign o_tick = r_tick;
endmodule

// Top: decodes the config write port onto channels and registers the mix.
module sq_multi_gen #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 12,
  parameter int CH_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_data,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             mix_mode,
  output logic [N_CH-1:0]  sq_out,
  output logic [N_CH-1:0]  tick,
  output logic             mix_out
);
  logic [N_CH-1:0] w_wr_hit;
  logic [N_CH-1:0] w_sq;
  logic [N_CH-1:0] w_tick;
  logic            r_mix;

  // Only indices below N_CH are decoded, so out-of-range channel selects
  // match nothing and the write is dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    sq_multi_gen_ch #(.DIV_W(DIV_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_en      (ch_en[i]),
      .i_wr      (w_wr_hit[i]),
      .i_wr_data (wr_data),
      .o_sq      (w_sq[i]),
      .o_tick    (w_tick[i])
    );
  end

  // Mix is taken from the registered channel outputs, so it trails them by one cycle.
  always_ff @(posedge clk) begin
    if (rst) r_mix <= 1'b0;
    else     r_mix <= mix_mode ? ^w_sq : |w_sq;
  end

  assign sq_out  = w_sq;
  assign tick    = w_tick;
  assign mix_out = r_mix;
endmodule

// File: tb/tb_sq_multi_gen.sv
// Directed bench for sq_multi_gen (N_CH=3, DIV_W=4 so both the max
// half-period and an out-of-range channel select are reachable).
module tb_sq_multi_gen;
  localparam int N_CH  = 3;
  localparam int DIV_W = 4;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [DIV_W-1:0] wr_data;
  logic [N_CH-1:0]  ch_en;
  logic             mix_mode;
  logic [N_CH-1:0]  sq_out;
  logic [N_CH-1:0]  tick;
  logic             mix_out;

  int nchk = 0;
  int errs = 0;

  sq_multi_gen #(.N_CH(N_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .ch_en    (ch_en),
    .mix_mode (mix_mode),
    .sq_out   (sq_out),
    .tick     (tick),
    .mix_out  (mix_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [N_CH-1:0] exp_sq, exp_tk, prev;
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; ch_en = '0; mix_mode = 1'b0;

    // Reset then idle
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst_sq", sq_out, 0); chk("rst_tick", tick, 0); chk("rst_mix", mix_out, 0);
    end
    rst = 1'b0;
    cyc();
    chk("idle_sq", sq_out, 0); chk("idle_mix", mix_out, 0);

    // Basic divide: ch0 H=3 -> toggles every 4 enabled edges
    wr(0, 4'd3);
    chk("wr_hold_sq", sq_out, 0);
    ch_en = 3'b001;
    prev = '0;
    for (int n = 1; n <= 19; n++) begin
      cyc();
      exp_sq = {2'b00, 1'((n / 4) % 2)};
      exp_tk = {2'b00, 1'(n % 4 == 0)};
      chk("div_sq", sq_out, exp_sq);
      chk("div_tick", tick, exp_tk);
      chk("div_mix", mix_out, |prev);
      prev = exp_sq;
    end

    // Write collision: cnt==3 now, write H=1 -> no toggle, restart
    wr(0, 4'd1);
    chk("coll_sq", sq_out, 0);
    chk("coll_tick", tick, 0);
    for (int m = 1; m <= 6; m++) begin
      cyc();
      chk("coll_sq2", sq_out, {2'b00, 1'((m / 2) % 2)});
      chk("coll_tick2", tick, {2'b00, 1'(m % 2 == 0)});
    end

    // Mix modes: ch0 H=0, ch1 H=1; XOR from edge 9; out-of-range write at edge 9
    ch_en = '0;
    do_reset();
    wr(0, 4'd0);
    wr(1, 4'd1);
    ch_en = 3'b011;
    prev = '0;
    for (int n = 1; n <= 14; n++) begin
      if (n == 9) begin
        mix_mode = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd3; wr_data = 4'd5;
      end
      cyc();
      wr_en = 1'b0;
      exp_sq = {1'b0, 1'((n / 2) % 2), 1'(n % 2)};
      exp_tk = {1'b0, 1'(n % 2 == 0), 1'b1};
      chk("mix_sq", sq_out, exp_sq);
      chk("mix_tick", tick, exp_tk);
      chk(n >= 9 ? "mix_xor" : "mix_or", mix_out, n >= 9 ? ^prev : |prev);
      prev = exp_sq;
    end
    mix_mode = 1'b0;

    // Max H on ch2: period 32, clean wrap
    ch_en = '0;
    do_reset();
    wr(2, 4'd15);
    ch_en = 3'b100;
    for (int n = 1; n <= 64; n++) begin
      cyc();
      chk("max_sq", sq_out, {1'((n / 16) % 2), 2'b00});
      chk("max_tick", tick, {1'(n % 16 == 0), 2'b00});
    end

    // Disable mid-high: ch0 (H=0 after reset) goes high, then drop enable
    ch_en = 3'b001;
    cyc();
    chk("dis_hi", sq_out, 3'b001);
    ch_en = 3'b000;
    cyc();
    chk("dis_sq", sq_out, 0);
    chk("dis_tick", tick, 0);

    // Reset mid-run: ch0 H=0, ch2 H=15 running
    ch_en = 3'b101;
    for (int n = 1; n <= 21; n++) cyc();
    chk("run_sq", sq_out, 3'b101);
    rst = 1'b1;
    cyc();
    chk("mrst_sq", sq_out, 0); chk("mrst_tick", tick, 0); chk("mrst_mix", mix_out, 0);
    rst = 1'b0;
    cyc();
    chk("rest_sq1", sq_out, 3'b101);
    chk("rest_tk1", tick, 3'b101);
    cyc();
    chk("rest_sq2", sq_out, 3'b000);
    chk("rest_mix", mix_out, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/sq_multi_gen.md
Name: sq_multi_gen

Overview:
Parametrised multi-channel square-wave generator. It is the successor to the single-shot combinational OR-mix demo top: each of N_CH channels divides clk by a programmable half-period, and the channels are combined into one registered mix output (OR or XOR). It sits behind the chip top-level pin wrapper, which maps the config write port and outputs onto ui/uo/uio pins.

Parameters:
N_CH, 4, number of independent square-wave channels (1..8)
DIV_W, 12, width of per-channel half-period register and counter
CH_W, 2, width of channel select; 2^CH_W >= N_CH required

Ports:
clk  input  1  single system clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  config write strobe, sampled on rising clk
wr_ch  input  CH_W  target channel for write
wr_data  input  DIV_W  new half-period value H for wr_ch
ch_en  input  N_CH  per-channel run enable, level-sensitive
mix_mode  input  1  0 = OR mix, 1 = XOR mix
sq_out  output  N_CH  per-channel square wave, registered
tick  output  N_CH  one-cycle pulse on the cycle sq_out[i] toggles
mix_out  output  1  registered mix of sq_out

Behaviour:
- Reset (rst=1 at edge): all H[i]=0, cnt[i]=0, sq_out=0, tick=0, mix_out=0. Reset overrides writes and enables. Reset mid-operation aborts any count with no residual state.
- Per channel i, when ch_en[i]=1 and no write to i this cycle:
  - cnt[i]==H[i]: cnt[i]<=0, sq_out[i]<=~sq_out[i], tick[i]<=1.
  - otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
  - Period = 2*(H+1) cycles. H=0 gives clk/2. H=2^DIV_W-1 gives max period 2^(DIV_W+1). No counter overflow is possible because cnt never exceeds H.
- ch_en[i]=0: cnt[i]<=0, sq_out[i]<=0, tick[i]<=0 on the next edge. Re-enable starts from cnt=0, sq_out=0. The first rising toggle occurs H+1 cycles after the first enabled edge.
- Write (wr_en=1, wr_ch<N_CH): H[wr_ch]<=wr_data and cnt[wr_ch]<=0 at the same edge.
  - sq_out[wr_ch] holds its value and tick[wr_ch]=0 that cycle.
  - A write wins over a simultaneous terminal count: no toggle.
  - Writes are accepted whether or not the channel is enabled.
- wr_ch>=N_CH: write ignored; no state changes.
- Other channels are unaffected by a write to one channel.
- mix_out <= mix_mode ? ^sq_out : |sq_out, registered from the current sq_out register value. It lags sq_out by exactly one cycle. mix_mode changes take effect on the next edge.
- tick[i] asserts in the same cycle that the new sq_out[i] value is visible.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, ch_en=0 -> sq_out=0, tick=0, mix_out=0 on every cycle. All cnt=0.
- Basic divide: write ch0 H=3, ch_en=0001 -> sq_out[0] rises 4 cycles after enable, then toggles every 4 cycles (period 8). tick[0] pulses once per toggle. mix_out (OR) follows sq_out[0] delayed 1 cycle.
- Min/max H: ch1 H=0 -> sq_out[1] toggles every cycle. With DIV_W=4 (override), ch2 H=15 -> period 32 cycles with no glitch at wrap.
- Write collision: ch0 H=3 running, write ch0 H=1 exactly on the cycle cnt==3 -> no toggle that cycle, cnt=0. Subsequent toggles occur every 2 cycles.
- Mix modes: ch0 H=0, ch1 H=1, both enabled. OR mode -> mix_out=|{sq1,sq0} delayed 1. Switch mix_mode=1 -> next cycle mix_out=sq0^sq1 delayed 1. Out-of-range write wr_ch=3 with N_CH=3 -> no change to any H.
- Disable/reset mid-run: drop ch_en[0] while sq_out[0]=1 -> 0 next cycle. Assert rst during an active count -> all outputs 0 next edge. After release with ch_en held, ch0 restarts with H=0 (clk/2).
